// File: rtl/gpio_serial_loader_if.sv
// gpio_serial_loader_if
//   Bundles the sequencer's handshake, register-file fetch and pad-chain
//   signals.
//   master : the loader (drives busy/done/cfg_addr/serial_*).
//   slave  : the surrounding logic (drives start/cfg_data and optionally abort).
//   Ports:
//     start        request a full chain load (1 cycle)
//     busy, done   load in progress / one-cycle completion pulse
//     cfg_addr     pad index being fetched
//     cfg_data     pad config word for cfg_addr
//     serial_clock, serial_data, serial_load   pad-chain shift/latch lines
//     abort        only present with GPIO_SERIAL_LOADER_ABORT_EN defined
interface gpio_serial_loader_if #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

  logic                start;
  logic                busy;
  logic                done;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_data;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;
`ifdef GPIO_SERIAL_LOADER_ABORT_EN
  logic                abort;

  modport master (
    input  start, cfg_data, abort,
    output busy, done, cfg_addr, serial_clock, serial_data, serial_load
  );
  modport slave (
    output start, cfg_data, abort,
    input  busy, done, cfg_addr, serial_clock, serial_data, serial_load
  );
`else
  modport master (
    input  start, cfg_data,
    output busy, done, cfg_addr, serial_clock, serial_data, serial_load
  );
  modport slave (
    output start, cfg_data,
    input  busy, done, cfg_addr, serial_clock, serial_data, serial_load
  );
`endif
endinterface

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Loads every pad's CFG_BITS config word into the GPIO control-block shift
//   chain, furthest pad first, MSB first, then strobes serial_load so all
//   blocks latch together.
//   Ports:
//     clock  system clock (rising edge)
//     reset  synchronous, active-high
//     bus    gpio_serial_loader_if.master (start/busy/done, cfg_addr/cfg_data,
//            serial_clock/serial_data/serial_load)
//   Optional: define GPIO_SERIAL_LOADER_ABORT_EN to add bus.abort, which
//   cancels an in-flight load without a serial_load or done pulse.
module gpio_serial_loader #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  gpio_serial_loader_if.master bus
);

  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_IO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state;
  logic [7:0]          half_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [CFG_BITS-1:0] shreg;
  logic [AW-1:0]       addr_q;
  logic                busy_q, done_q, sck_q, sld_q;
  logic                abort_req;

`ifdef GPIO_SERIAL_LOADER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // serial_data is the MSB of the shift register. The register is zero outside
  // SHIFT (all CFG_BITS bits have been shifted out by the end of each pad),
  // which keeps the data line low in FETCH/LOAD/IDLE.
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_addr     = addr_q;
  assign bus.serial_clock = sck_q;
  assign bus.serial_data  = shreg[CFG_BITS-1];
  assign bus.serial_load  = sld_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      sld_q    <= 1'b0;
    end else if (abort_req && (state == S_FETCH || state == S_SHIFT || state == S_LOAD)) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      sck_q    <= 1'b0;
      sld_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_FETCH;
            busy_q <= 1'b1;
            addr_q <= ADDR_LAST;
          end
        end

        // cfg_data for the new cfg_addr is valid during this single cycle.
        S_FETCH: begin
          shreg    <= bus.cfg_data;
          sck_q    <= 1'b0;
          half_cnt <= '0;
          bit_cnt  <= '0;
          state    <= S_SHIFT;
        end

        // Each bit: CLK_DIV cycles low, CLK_DIV cycles high; the data moves on
        // only at the high->low transition so it is stable across the rise.
        S_SHIFT: begin
          if (half_cnt == DIV_LAST) begin
            half_cnt <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              shreg <= shreg << 1;
              if (bit_cnt == BIT_LAST) begin
                if (addr_q != '0) begin
                  addr_q <= addr_q - AW'(1);
                  state  <= S_FETCH;
                end else begin
                  sld_q <= 1'b1;
                  state <= S_LOAD;
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        // Strobe high for CLK_DIV cycles, then a CLK_DIV-cycle low tail.
        S_LOAD: begin
          if (half_cnt == DIV_LAST) begin
            half_cnt <= '0;
            if (sld_q) begin
              sld_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        // start is ignored here; it is only looked at in IDLE.
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
module tb_gpio_serial_loader;
  localparam int B = 13;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic abort;
  logic sel;          // 0: 2-pad CLK_DIV=1 instance, 1: default instance

  always #5 clock = ~clock;

  gpio_serial_loader_if #(.NUM_IO(2),  .CFG_BITS(B)) if_s ();
  gpio_serial_loader_if #(.NUM_IO(38), .CFG_BITS(B)) if_d ();

  gpio_serial_loader #(.NUM_IO(2), .CFG_BITS(B), .CLK_DIV(1)) dut_s (
    .clock(clock), .reset(reset), .bus(if_s.master));
  gpio_serial_loader dut_d (
    .clock(clock), .reset(reset), .bus(if_d.master));

  // Register-file model: word for cfg_addr is presented in the fetch cycle.
  logic [B-1:0] mem [0:63];
  assign if_s.cfg_data = mem[{5'd0, if_s.cfg_addr}];
  assign if_d.cfg_data = mem[if_d.cfg_addr];
  assign if_s.start    = start & ~sel;
  assign if_d.start    = start &  sel;
`ifdef GPIO_SERIAL_LOADER_ABORT_EN
  assign if_s.abort    = abort & ~sel;
  assign if_d.abort    = abort &  sel;
`endif

  logic       busy_m, done_m, sck_m, sda_m, sld_m;
  logic [5:0] addr_m;
  assign busy_m = sel ? if_d.busy         : if_s.busy;
  assign done_m = sel ? if_d.done         : if_s.done;
  assign sck_m  = sel ? if_d.serial_clock : if_s.serial_clock;
  assign sda_m  = sel ? if_d.serial_data  : if_s.serial_data;
  assign sld_m  = sel ? if_d.serial_load  : if_s.serial_load;
  assign addr_m = sel ? if_d.cfg_addr     : 6'(if_s.cfg_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic sel;
    int   fill;        // 0: 1ABC/0055, 1: all 1803, 2: random
    int   restart_at;  // cycle to pulse start again (0 = never)
    int   reset_at;    // cycle to pulse reset (0 = never)
    int   abort_at;    // cycle to pulse abort (0 = never)
    int   exp_lat;
    int   exp_rises;
    int   exp_ld;
  } vec_t;

  // One load, observed at negedges. Cycle 1 is the cycle after the edge that
  // sampled start. The expected serial stream comes from the register-file
  // contents: pad NUM_IO-1 first, each word MSB first.
  task automatic run_load(input string tag, input vec_t v);
    int   nio, div, cyc, budget, rises, ld_hi, done_cnt, done_cyc;
    int   busy_err, stab_err, addr_err, idle_err, exp_addr, rest_q;
    bit   interrupted;
    logic psck, psda;
    logic got[$];
    logic exp_q[$];
    logic [B-1:0] gw, ew;

    nio = v.sel ? 38 : 2;
    div = v.sel ? 2 : 1;
    sel = v.sel;
    for (int p = nio - 1; p >= 0; p--)
      for (int b = B - 1; b >= 0; b--) exp_q.push_back(mem[p][b]);
    interrupted = (v.reset_at > 0) || (v.abort_at > 0);

    rises = 0; ld_hi = 0; done_cnt = 0; done_cyc = -1;
    busy_err = 0; stab_err = 0; addr_err = 0; idle_err = 0;
    exp_addr = nio - 1;
    budget = v.exp_lat + 20;

    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 1; psck = 1'b0; psda = 1'b0;
    while (cyc <= budget) begin
      if (v.reset_at > 0 && cyc == v.reset_at + 1) begin
        check({tag, "_rst_busy"}, busy_m, 0);
        check({tag, "_rst_sck"},  sck_m,  0);
        check({tag, "_rst_sda"},  sda_m,  0);
        check({tag, "_rst_sld"},  sld_m,  0);
        check({tag, "_rst_done"}, done_m, 0);
        check({tag, "_rst_addr"}, addr_m, 0);
        reset = 1'b0;
      end
      if (v.abort_at > 0 && cyc == v.abort_at + 1) begin
        check({tag, "_abt_busy"}, busy_m, 0);
        check({tag, "_abt_sck"},  sck_m,  0);
        check({tag, "_abt_sda"},  sda_m,  0);
        check({tag, "_abt_addr"}, addr_m, 0);
        abort = 1'b0;
      end
      if (v.restart_at > 0 && cyc == v.restart_at + 1) start = 1'b0;

      if (done_cyc < 0) begin
        if (sck_m && !psck) begin
          rises++;
          got.push_back(sda_m);
        end
        if (psck && sck_m && sda_m != psda) stab_err++;
        if (sld_m) ld_hi++;
        if (sld_m && (sck_m || sda_m)) stab_err++;
        if (!busy_m && sda_m) stab_err++;
        if (busy_m && addr_m != 6'(exp_addr)) begin
          if (exp_addr > 0 && addr_m == 6'(exp_addr - 1)) exp_addr--;
          else addr_err++;
        end
      end else if (cyc > done_cyc) begin
        if (v.restart_at == v.exp_lat + 1 && cyc == v.exp_lat + 2)
          check({tag, "_start_after_done"}, busy_m, 1);
        else if (v.restart_at != v.exp_lat + 1 && busy_m) idle_err++;
      end
      if (done_m) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy_m) busy_err++;
      end

      if (v.restart_at > 0 && cyc == v.restart_at) start = 1'b1;
      if (v.reset_at   > 0 && cyc == v.reset_at)   reset = 1'b1;
      if (v.abort_at   > 0 && cyc == v.abort_at)   abort = 1'b1;
      psck = sck_m;
      psda = sda_m;
      @(negedge clock);
      cyc++;
    end

    if (interrupted) begin
      check({tag, "_no_load"}, ld_hi, 0);
      check({tag, "_no_done"}, done_cnt, 0);
    end else begin
      check({tag, "_rises"},    rises, v.exp_rises);
      check({tag, "_load_hi"},  ld_hi, v.exp_ld);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_cyc"}, done_cyc, v.exp_lat);
      check({tag, "_done_busy"}, busy_err, 0);
      check({tag, "_stable"},   stab_err, 0);
      check({tag, "_addr_seq"}, addr_err, 0);
      check({tag, "_addr_end"}, exp_addr, 0);
      check({tag, "_idle_after"}, idle_err, 0);
      if (got.size() == exp_q.size()) begin
        for (int p = 0; p < nio; p++) begin
          gw = '0; ew = '0;
          for (int b = 0; b < B; b++) begin
            gw = {gw[B-2:0], got[p*B + b]};
            ew = {ew[B-2:0], exp_q[p*B + b]};
          end
          check({tag, "_word"}, int'(gw), int'(ew));
        end
      end
    end

    // A start right after DONE launched a second load; let it drain.
    rest_q = 0;
    while (busy_m && rest_q < 5000) begin
      @(negedge clock);
      rest_q++;
    end
    if (rest_q >= 5000) check({tag, "_drain_timeout"}, 1, 0);
    repeat (3) @(negedge clock);
  endtask

  vec_t vecs[$];

  initial begin
    int quiet_s, quiet_d;
    vecs.push_back('{1'b0, 0, 0,  0,  0, 57,   26,  1});
    vecs.push_back('{1'b0, 2, 0,  0,  0, 57,   26,  1});
    vecs.push_back('{1'b0, 2, 57, 0,  0, 57,   26,  1});  // start in DONE
    vecs.push_back('{1'b0, 2, 58, 0,  0, 57,   26,  1});  // start after DONE
    vecs.push_back('{1'b0, 2, 0,  20, 0, 57,   26,  1});  // reset mid-SHIFT
    vecs.push_back('{1'b0, 2, 0,  0,  0, 57,   26,  1});
    vecs.push_back('{1'b1, 1, 0,  0,  0, 2019, 494, 2});
    vecs.push_back('{1'b1, 1, 100, 0, 0, 2019, 494, 2});  // start while busy
    vecs.push_back('{1'b1, 2, 0,  300, 0, 2019, 494, 2}); // reset mid-SHIFT
    vecs.push_back('{1'b1, 2, 0,  0,  0, 2019, 494, 2});
`ifdef GPIO_SERIAL_LOADER_ABORT_EN
    vecs.push_back('{1'b0, 2, 0,  0,  10,  57,   26,  1});
    vecs.push_back('{1'b1, 2, 0,  0,  500, 2019, 494, 2});
    vecs.push_back('{1'b0, 2, 0,  0,  0,   57,   26,  1});
`endif

    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    quiet_s = 0; quiet_d = 0;
    repeat (20) begin
      @(negedge clock);
      if (if_s.busy || if_s.done || if_s.serial_clock || if_s.serial_data ||
          if_s.serial_load || if_s.cfg_addr != '0) quiet_s++;
      if (if_d.busy || if_d.done || if_d.serial_clock || if_d.serial_data ||
          if_d.serial_load || if_d.cfg_addr != '0) quiet_d++;
    end
    check("reset_idle_small", quiet_s, 0);
    check("reset_idle_default", quiet_d, 0);

    foreach (vecs[k]) begin
      for (int i = 0; i < 64; i++) begin
        case (vecs[k].fill)
          0:       mem[i] = (i == 1) ? 13'h1ABC : (i == 0) ? 13'h0055 : '0;
          1:       mem[i] = 13'h1803;
          default: mem[i] = B'($urandom);
        endcase
      end
      run_load($sformatf("v%0d", k), vecs[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
